// File: rtl/armleocpu_avl_pkg.sv
// ============================================================================
// Module   : armleocpu_avl_pkg
// Purpose  : Avalon-MM response codes and responder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package armleocpu_avl_pkg;

   localparam logic [1:0] AVL_RESP_OKAY        = 2'b00;
   localparam logic [1:0] AVL_RESP_SLAVEERROR  = 2'b10;
   localparam logic [1:0] AVL_RESP_DECODEERROR = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      RESPOND = 2'd2
   } avl_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/armleocpu_avl_mem_array.sv
// ============================================================================
// Module   : armleocpu_avl_mem_array
// Purpose  : Single-port byte-enabled synchronous RAM, registered read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module armleocpu_avl_mem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic [AW-1:0] i_addr,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // Read register only moves on a read so it holds the captured word
   // until the response is presented.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int l = 0; l < 4; l++) begin
            if (i_be[l]) begin
               r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
            end
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/armleocpu_avl_mem_responder.sv
// ============================================================================
// Module   : armleocpu_avl_mem_responder
// Purpose  : Avalon-MM RAM responder with programmable stall and read latency.
//            Optional ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN adds inject_error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module armleocpu_avl_mem_responder
   import armleocpu_avl_pkg::*;
#(
   parameter logic [33:0] BASE_ADDR    = 34'h0_0000_0000,
   parameter int          DEPTH_WORDS  = 1024,
   parameter int          WAIT_CYCLES  = 0,
   parameter int          READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [33:0] avl_address,
   input  logic        avl_read,
   input  logic        avl_write,
   input  logic [31:0] avl_writedata,
   input  logic [3:0]  avl_byteenable,
`ifdef ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN
   input  logic        inject_error,
`endif
   output logic        avl_waitrequest,
   output logic [31:0] avl_readdata,
   output logic        avl_readdatavalid,
   output logic [1:0]  avl_response
);

   localparam int          c_aw   = $clog2(DEPTH_WORDS);
   localparam logic [33:0] c_span = 34'(DEPTH_WORDS * 4);
   localparam logic [3:0]  c_wait = 4'(WAIT_CYCLES);
   localparam logic [3:0]  c_lat  = 4'(READ_LATENCY);
   localparam logic        c_lat1 = (READ_LATENCY == 1);

   avl_resp_state_t r_state, w_state_nxt;
   logic [3:0]      r_stall_cnt, w_stall_nxt;
   logic [3:0]      r_lat_cnt, w_lat_nxt;
   logic [1:0]      r_resp;
   logic            w_accept;
   logic            w_req;
   logic            w_inject;
   logic [33:0]     w_offset;
   logic            w_in_range;
   logic            w_aligned;
   logic [1:0]      w_resp_rd;
   logic            w_mem_we;
   logic            w_mem_re;
   logic [31:0]     w_ram_q;

`ifdef ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN
   assign w_inject = inject_error;
`else
   assign w_inject = 1'b0;
`endif

   assign w_req      = avl_read | avl_write;
   assign w_offset   = avl_address - BASE_ADDR;
   assign w_in_range = (w_offset < c_span);
   assign w_aligned  = (avl_address[1:0] == 2'b00);

   // Simultaneous read+write is treated as a faulted read.
   always_comb begin
      w_resp_rd = AVL_RESP_OKAY;
      if (w_inject || avl_write) begin
         w_resp_rd = AVL_RESP_SLAVEERROR;
      end else if (!w_in_range) begin
         w_resp_rd = AVL_RESP_DECODEERROR;
      end else if (!w_aligned) begin
         w_resp_rd = AVL_RESP_SLAVEERROR;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_stall_nxt     = r_stall_cnt;
      w_lat_nxt       = r_lat_cnt;
      avl_waitrequest = 1'b1;
      w_accept        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_req) begin
               avl_waitrequest = 1'b0;
            end else if (r_stall_cnt < c_wait) begin
               w_stall_nxt = r_stall_cnt + 4'd1;
            end else begin
               avl_waitrequest = 1'b0;
               w_accept        = 1'b1;
               w_stall_nxt     = 4'd0;
            end
         end
         PENDING: begin
            if (r_lat_cnt >= c_lat - 4'd1) begin
               w_state_nxt = RESPOND;
            end else begin
               w_lat_nxt = r_lat_cnt + 4'd1;
            end
         end
         RESPOND: begin
            avl_waitrequest = 1'b0;
            w_accept        = w_req;
            w_state_nxt     = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (w_accept && avl_read) begin
         w_state_nxt = c_lat1 ? RESPOND : PENDING;
         w_lat_nxt   = 4'd1;
      end
      if (rst) begin
         avl_waitrequest = 1'b1;
         w_accept        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_stall_cnt <= 4'd0;
         r_lat_cnt   <= 4'd0;
         r_resp      <= AVL_RESP_OKAY;
      end else begin
         r_state     <= w_state_nxt;
         r_stall_cnt <= w_stall_nxt;
         r_lat_cnt   <= w_lat_nxt;
         if (w_accept && avl_read) begin
            r_resp <= w_resp_rd;
         end
      end
   end

   assign w_mem_we = w_accept && avl_write && !avl_read && w_in_range && w_aligned && !w_inject;
   assign w_mem_re = w_accept && avl_read;

   armleocpu_avl_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (c_aw)
   ) u_mem (
      .clk     (clk),
      .i_addr  (w_offset[c_aw+1:2]),
      .i_we    (w_mem_we),
      .i_re    (w_mem_re),
      .i_be    (avl_byteenable),
      .i_wdata (avl_writedata),
      .o_rdata (w_ram_q)
   );

   assign avl_readdatavalid = (r_state == RESPOND) && !rst;
   assign avl_response      = avl_readdatavalid ? r_resp : AVL_RESP_OKAY;
   assign avl_readdata      = (avl_readdatavalid && (r_resp == AVL_RESP_OKAY)) ? w_ram_q : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_armleocpu_avl_mem_responder.sv
// ============================================================================
// Module   : tb_armleocpu_avl_mem_responder
// Purpose  : Directed self-checking bench; dut 0 default timing, dut 1 with
//            WAIT_CYCLES=3 / READ_LATENCY=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_armleocpu_avl_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [33:0] addr   [2];
   logic        rd     [2];
   logic        wr     [2];
   logic [31:0] wdata  [2];
   logic [3:0]  be     [2];
   logic        wreq   [2];
   logic [31:0] rdata  [2];
   logic        rvalid [2];
   logic [1:0]  resp   [2];
`ifdef ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN
   logic        inj    [2];
`endif

   int n_total = 0;
   int n_bad   = 0;
   int vcnt [2];

   always #5 clk = ~clk;

   armleocpu_avl_mem_responder u_dut0 (
      .clk               (clk),
      .rst               (rst),
      .avl_address       (addr[0]),
      .avl_read          (rd[0]),
      .avl_write         (wr[0]),
      .avl_writedata     (wdata[0]),
      .avl_byteenable    (be[0]),
`ifdef ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN
      .inject_error      (inj[0]),
`endif
      .avl_waitrequest   (wreq[0]),
      .avl_readdata      (rdata[0]),
      .avl_readdatavalid (rvalid[0]),
      .avl_response      (resp[0])
   );

   armleocpu_avl_mem_responder #(
      .WAIT_CYCLES  (3),
      .READ_LATENCY (4)
   ) u_dut1 (
      .clk               (clk),
      .rst               (rst),
      .avl_address       (addr[1]),
      .avl_read          (rd[1]),
      .avl_write         (wr[1]),
      .avl_writedata     (wdata[1]),
      .avl_byteenable    (be[1]),
`ifdef ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN
      .inject_error      (inj[1]),
`endif
      .avl_waitrequest   (wreq[1]),
      .avl_readdata      (rdata[1]),
      .avl_readdatavalid (rvalid[1]),
      .avl_response      (resp[1])
   );

   always @(negedge clk) begin
      #2;
      for (int k = 0; k < 2; k++) begin
         if (rvalid[k] === 1'b1) vcnt[k]++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request and hold it until the accepting edge; returns stall count.
   task automatic xfer(input int k, input bit r, input bit w, input logic [33:0] a,
                       input logic [31:0] d, input logic [3:0] b, output int stalls);
      stalls = 0;
      @(negedge clk);
      addr[k] = a; rd[k] = r; wr[k] = w; wdata[k] = d; be[k] = b;
      #1;
      while (wreq[k] !== 1'b0 && stalls < 50) begin
         @(negedge clk); #1;
         stalls++;
      end
      chk("accept_bound", 64'(stalls < 50), 64'd1);
      @(posedge clk); #1;
      rd[k] = 1'b0; wr[k] = 1'b0;
   endtask

   // Cycles from the accepting edge until readdatavalid, plus the response.
   task automatic wait_valid(input int k, output int lat, output bit wok,
                             output logic [31:0] d, output logic [1:0] r);
      lat = 0; wok = 1'b1;
      do begin
         @(negedge clk); #1;
         lat++;
         if (rvalid[k] !== 1'b1 && wreq[k] !== 1'b1) wok = 1'b0;
      end while (rvalid[k] !== 1'b1 && lat < 30);
      chk("valid_bound", 64'(lat < 30), 64'd1);
      d = rdata[k];
      r = resp[k];
   endtask

   task automatic rd_check(input int k, input string tag, input logic [33:0] a,
                           input int exp_st, input int exp_lat,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
      int st, lat;
      bit wok;
      logic [31:0] d;
      logic [1:0]  r;
      xfer(k, 1'b1, 1'b0, a, 32'h0, 4'h0, st);
      wait_valid(k, lat, wok, d, r);
      chk({tag, "_stall"}, 64'(st), 64'(exp_st));
      chk({tag, "_lat"},   64'(lat), 64'(exp_lat));
      chk({tag, "_wait"},  64'(wok), 64'd1);
      chk({tag, "_data"},  64'(d), 64'(exp_d));
      chk({tag, "_resp"},  64'(r), 64'(exp_r));
   endtask

   int          st, lat;
   bit          wok;
   logic [31:0] d;
   logic [1:0]  r;

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         addr[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0; wdata[k] = '0; be[k] = '0;
         vcnt[k] = 0;
`ifdef ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN
         inj[k] = 1'b0;
`endif
      end
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_wait",   64'(wreq[k]),   64'd1);
         chk("rst_valid",  64'(rvalid[k]), 64'd0);
         chk("rst_rdata",  64'(rdata[k]),  64'd0);
         chk("rst_resp",   64'(resp[k]),   64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic write then read, default timing
      xfer(0, 1'b0, 1'b1, 34'h10, 32'hDEAD_BEEF, 4'hF, st);
      chk("s1_wr_stall", 64'(st), 64'd0);
      rd_check(0, "s1_rd", 34'h10, 0, 1, 32'hDEAD_BEEF, 2'b00);

      // Stall and latency
      xfer(1, 1'b0, 1'b1, 34'h10, 32'hCAFE_F00D, 4'hF, st);
      chk("s2_wr_stall", 64'(st), 64'd3);
      rd_check(1, "s2_rd", 34'h10, 3, 4, 32'hCAFE_F00D, 2'b00);

      // Decode and alignment errors
      rd_check(0, "s3_oor", 34'h1_0000_0000, 0, 1, 32'h0, 2'b11);
      rd_check(0, "s3_mis", 34'h12, 0, 1, 32'h0, 2'b10);
      xfer(0, 1'b0, 1'b1, 34'h12, 32'hFFFF_FFFF, 4'hF, st);
      rd_check(0, "s3_keep", 34'h10, 0, 1, 32'hDEAD_BEEF, 2'b00);
      xfer(0, 1'b1, 1'b1, 34'h10, 32'h0, 4'hF, st);
      wait_valid(0, lat, wok, d, r);
      chk("s3_rw_resp", 64'(r), 64'd2);
      chk("s3_rw_data", 64'(d), 64'd0);
      rd_check(0, "s3_rw_keep", 34'h10, 0, 1, 32'hDEAD_BEEF, 2'b00);

      // Partial byte-lane write
      xfer(0, 1'b0, 1'b1, 34'h20, 32'h1122_3344, 4'hF, st);
      xfer(0, 1'b0, 1'b1, 34'h20, 32'h0000_AB00, 4'b0010, st);
      rd_check(0, "s4_be", 34'h20, 0, 1, 32'h1122_AB44, 2'b00);

      // Back-to-back read presented in the RESPOND cycle
      xfer(1, 1'b0, 1'b1, 34'h40, 32'h5555_AAAA, 4'hF, st);
      vcnt[1] = 0;
      xfer(1, 1'b1, 1'b0, 34'h10, 32'h0, 4'h0, st);
      wait_valid(1, lat, wok, d, r);
      chk("s5_first_data", 64'(d), 64'hCAFE_F00D);
      addr[1] = 34'h40; rd[1] = 1'b1;
      #1;
      chk("s5_no_stall", 64'(wreq[1]), 64'd0);
      @(posedge clk); #1;
      rd[1] = 1'b0;
      wait_valid(1, lat, wok, d, r);
      chk("s5_second_lat",  64'(lat), 64'd4);
      chk("s5_second_data", 64'(d), 64'h5555_AAAA);
      repeat (8) @(negedge clk);
      #3;
      chk("s5_pulses", 64'(vcnt[1]), 64'd2);

      // Reset while a read is pending
      xfer(1, 1'b1, 1'b0, 34'h10, 32'h0, 4'h0, st);
      vcnt[1] = 0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("s6_wait0",  64'(wreq[0]),   64'd1);
      chk("s6_wait1",  64'(wreq[1]),   64'd1);
      chk("s6_valid",  64'(rvalid[1]), 64'd0);
      chk("s6_rdata",  64'(rdata[1]),  64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #3;
      chk("s6_no_resp", 64'(vcnt[1]), 64'd0);
      rd_check(0, "s6_after", 34'h10, 0, 1, 32'hDEAD_BEEF, 2'b00);

`ifdef ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN
      inj[0] = 1'b1;
      xfer(0, 1'b1, 1'b0, 34'h10, 32'h0, 4'h0, st);
      inj[0] = 1'b0;
      wait_valid(0, lat, wok, d, r);
      chk("inj_resp", 64'(r), 64'd2);
      chk("inj_data", 64'(d), 64'd0);
      inj[0] = 1'b1;
      xfer(0, 1'b0, 1'b1, 34'h10, 32'h0, 4'hF, st);
      inj[0] = 1'b0;
      rd_check(0, "inj_wr_drop", 34'h10, 0, 1, 32'hDEAD_BEEF, 2'b00);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/armleocpu_avl_mem_responder.md
Name: armleocpu_avl_mem_responder

Overview:
- Avalon-MM responder (slave) modelling a word-addressed RAM region, with programmable stall and read latency.
- It is the far end of the 34-bit-address, 32-bit-data, burstcount-1 read/write interface driven by the page-table walker and other initiators.
- It returns avl_response codes for decode errors and misaligned accesses.
- It is used as the on-chip page-table/boot RAM and as the bench responder for initiator verification.

Parameters:
- BASE_ADDR, 34'h0_0000_0000: byte address of word 0; must be DEPTH_WORDS*4-aligned.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 0: cycles avl_waitrequest is held high on a new request from IDLE before acceptance; range 0..15.
- READ_LATENCY, 1: cycles from read acceptance to avl_readdatavalid; range 1..8.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- avl_address  input  34  byte address
- avl_read  input  1  read request
- avl_write  input  1  write request
- avl_writedata  input  32  write data
- avl_byteenable  input  4  write byte lanes
- avl_waitrequest  output  1  request not accepted this cycle
- avl_readdata  output  32  read data, valid with avl_readdatavalid
- avl_readdatavalid  output  1  read response strobe
- avl_response  output  2  00 OKAY, 10 SLAVEERROR, 11 DECODEERROR; valid with avl_readdatavalid

Behaviour:
- Reset: one clock, synchronous, active-high; port names are clk and rst. While rst=1: avl_waitrequest=1, avl_readdatavalid=0, avl_readdata=0, avl_response=00, state=IDLE, counters=0. Memory array is not reset. Reset mid-transfer drops any pending read with no response.
- Request is avl_read|avl_write. A request is accepted in any cycle where it is present and avl_waitrequest=0.
- States and transitions:
  - IDLE: with no request, avl_waitrequest=0. With a request and stall_cnt<WAIT_CYCLES: avl_waitrequest=1, stall_cnt increments. With a request and stall_cnt==WAIT_CYCLES: avl_waitrequest=0, request accepted, stall_cnt cleared. A write stays in IDLE; a read goes to PENDING with lat_cnt=1.
  - PENDING: avl_waitrequest=1. While lat_cnt<READ_LATENCY, lat_cnt increments. When lat_cnt==READ_LATENCY the block enters RESPOND in that same cycle, so the response appears exactly READ_LATENCY cycles after acceptance. When READ_LATENCY=1, acceptance goes directly to RESPOND on the next cycle.
  - RESPOND: exactly one cycle. avl_readdatavalid=1 and avl_waitrequest=0 (initiators sample readdatavalid qualified by !waitrequest). A request present in this cycle is accepted immediately with no stall cycles; a read is then back-to-back.
- Decode, evaluated at acceptance:
  - offset = avl_address - BASE_ADDR.
  - offset >= DEPTH_WORDS*4: response 11, readdata 0.
  - else avl_address[1:0]!=0: response 10, readdata 0.
  - else: response 00, readdata = mem[offset[.. :2]].
- Read data and response are captured at acceptance and held unchanged until RESPOND. avl_readdata is 0 whenever avl_readdatavalid=0.
- Writes: only in-range, aligned writes update mem, per-lane under avl_byteenable, at the accepting edge. Erroneous writes are dropped silently (no write response channel).
- avl_read and avl_write both high: protocol violation. Handled as a read with response 10; the write is dropped.
- Address arithmetic is 34-bit unsigned. An address below BASE_ADDR wraps to a large offset and decodes as 11.
- At most one outstanding read at any time.

Optional Feature:
- Macro: ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN.
- When defined: extra input port inject_error (1 bit). If inject_error=1 at read acceptance, the response is forced to 10 and readdata to 0, regardless of decode. Writes accepted with inject_error=1 are dropped.
- When undefined: the port is absent and behaviour is decode-only.

Decomposition:
- Shared package armleocpu_avl_pkg holds:
  - localparams AVL_RESP_OKAY=2'b00, AVL_RESP_SLAVEERROR=2'b10, AVL_RESP_DECODEERROR=2'b11;
  - state encoding IDLE/PENDING/RESPOND.
- One natural sub-module: armleocpu_avl_mem_array, the byte-enabled synchronous RAM storage (DEPTH_WORDS x 32, one read/write port).

Test Plan:
- Defaults, write 32'hDEAD_BEEF to 0x0_0000_0010 with be=1111, then read it -> write accepted in cycle T (waitrequest=0); read accepted at T+1; readdatavalid at T+2 with readdata=DEAD_BEEF, response=00.
- WAIT_CYCLES=3, READ_LATENCY=4, read 0x10 -> waitrequest=1 for 3 cycles, accepted on the 4th; readdatavalid exactly 4 cycles after acceptance; waitrequest=1 throughout PENDING.
- Read 0x1_0000_0000 (out of range) -> response=11, readdata=0. Read 0x12 -> response=10, readdata=0. A following write to 0x12 leaves mem[4] unchanged.
- Partial write be=0010 with data 32'h0000_AB00 over 32'h1122_3344 -> readback 32'h1122_AB44.
- PTW-style two-level walk: read, release, re-read presented in the RESPOND cycle -> second read accepted with no stall; exactly two readdatavalid pulses, with correct data in order.
- rst asserted in PENDING -> no readdatavalid ever appears; waitrequest=1 during rst; first read after reset behaves as in scenario 1. With ARMLEOCPU_AVL_RESP_ERROR_INJECT_EN defined, inject_error=1 on an in-range read -> response=10.
